// File: rtl/uart_rx_oversampler_if.sv
// Serial receive link bundle: RxD line in, received byte plus status strobes out.
// The slave modport is the receiver; the master modport drives the line and observes results.
interface uart_rx_oversampler_if;
  logic       RxD;
  logic [7:0] RxData;
  logic       isNewData;
  logic       frameErr;
  logic       rxBusy;

  modport master (
    output RxD,
    input  RxData,
    input  isNewData,
    input  frameErr,
    input  rxBusy
  );

  modport slave (
    input  RxD,
    output RxData,
    output isNewData,
    output frameErr,
    output rxBusy
  );
endinterface

// File: rtl/uart_rx_oversampler.sv
// 16x-oversampled UART receiver: 2-flop synchronizer, mid-bit sampling, false-start and framing checks.
// Define RX_PARITY_EN to expect one even-parity bit between D7 and stop (8E1); otherwise 8N1.
module uart_rx_oversampler #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 230400,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_rx_oversampler_if.slave        rx_if
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BRK
  } state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_cnt, div_next;
  logic [TICK_W-1:0] tick_cnt, tick_next;
  logic [2:0]        bit_cnt, bit_next;
  logic [7:0]        shreg, shreg_next;
  logic [7:0]        rx_data, data_next;
  logic              new_data, nd_next;
  logic              frame_err, fe_next;
  logic              rx_meta, rx_s;
  logic              tick_en;
  logic              bit_end;
  logic              mid_start;
  logic              par_ok;

`ifdef RX_PARITY_EN
  logic              par_acc, par_next;
`endif

  // Synchronizer flops reset to 1 so a reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_if.RxD;
      rx_s    <= rx_meta;
    end
  end

  assign tick_en   = (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign bit_end   = tick_en && (tick_cnt == TICK_LAST);
  assign mid_start = tick_en && (tick_cnt == HALF_LAST);

`ifdef RX_PARITY_EN
  assign par_ok = ~par_acc;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
`ifdef RX_PARITY_EN
      par_acc   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      div_cnt   <= div_next;
      tick_cnt  <= tick_next;
      bit_cnt   <= bit_next;
      shreg     <= shreg_next;
      rx_data   <= data_next;
      new_data  <= nd_next;
      frame_err <= fe_next;
`ifdef RX_PARITY_EN
      par_acc   <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    div_next   = (state == S_IDLE || tick_en) ? '0 : div_cnt + DIV_W'(1);
    tick_next  = tick_en ? tick_cnt + TICK_W'(1) : tick_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    data_next  = rx_data;
    nd_next    = 1'b0;
    fe_next    = 1'b0;
`ifdef RX_PARITY_EN
    par_next   = par_acc;
`endif

    unique case (state)
      S_IDLE: begin
        tick_next = '0;
        if (!rx_s) state_next = S_START;
      end

      // Start bit is only committed once it is still low half a bit in.
      S_START: begin
        if (mid_start) begin
          tick_next = '0;
          if (rx_s) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
            bit_next   = '0;
`ifdef RX_PARITY_EN
            par_next   = 1'b0;
`endif
          end
        end
      end

      S_DATA: begin
        if (bit_end) begin
          tick_next  = '0;
          shreg_next = {rx_s, shreg[7:1]};
          bit_next   = bit_cnt + 3'd1;
`ifdef RX_PARITY_EN
          par_next   = par_acc ^ rx_s;
          if (bit_cnt == 3'd7) state_next = S_PARITY;
`else
          if (bit_cnt == 3'd7) state_next = S_STOP;
`endif
        end
      end

`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tick_next  = '0;
          par_next   = par_acc ^ rx_s;
          state_next = S_STOP;
        end
      end
`endif

      // Leaving at mid stop bit lets a back-to-back start edge be caught from IDLE.
      S_STOP: begin
        if (bit_end) begin
          tick_next = '0;
          if (rx_s && par_ok) begin
            data_next  = shreg;
            nd_next    = 1'b1;
            state_next = S_IDLE;
          end else begin
            fe_next    = 1'b1;
            state_next = S_BRK;
          end
        end
      end

      S_BRK: begin
        tick_next = '0;
        if (rx_s) state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign rx_if.RxData    = rx_data;
  assign rx_if.isNewData = new_data;
  assign rx_if.frameErr  = frame_err;
  assign rx_if.rxBusy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler at default parameters (434-clk bit time on the line).
// Honors RX_PARITY_EN to match the DUT build.
module tb_uart_rx_oversampler;

  localparam int unsigned BIT = 434;
`ifdef RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  uart_rx_oversampler_if rx_if ();

  uart_rx_oversampler dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pulse counts, pulse widths and captured data.
  int unsigned cyc = 0;
  int unsigned nd_cnt = 0;
  int unsigned fe_cnt = 0;
  int unsigned both_cnt = 0;
  int unsigned nd_long = 0;
  int unsigned fe_long = 0;
  int unsigned busy_at_nd = 0;
  int unsigned nd_time[$];
  logic [7:0]  nd_data[$];
  logic        nd_prev = 1'b0;
  logic        fe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.isNewData === 1'b1) begin
      nd_cnt++;
      nd_time.push_back(cyc);
      nd_data.push_back(rx_if.RxData);
      if (nd_prev) nd_long++;
      if (rx_if.rxBusy !== 1'b0) busy_at_nd++;
    end
    if (rx_if.frameErr === 1'b1) begin
      fe_cnt++;
      if (fe_prev) fe_long++;
    end
    if (rx_if.isNewData === 1'b1 && rx_if.frameErr === 1'b1) both_cnt++;
    nd_prev = (rx_if.isNewData === 1'b1);
    fe_prev = (rx_if.frameErr === 1'b1);
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_if.RxD = b;
    idle(BIT);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef RX_PARITY_EN
    drive_bit(^data);
`endif
    drive_bit(stop_bit);
  endtask

`ifdef RX_PARITY_EN
  task automatic send_bad_par(input logic [7:0] data);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(~(^data));
    drive_bit(1'b1);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx_if.RxD = 1'b1;
    reset = 1'b0;
    idle(5);
    check("rst_rxdata", rx_if.RxData, 8'h00);
    check("rst_newdata", rx_if.isNewData, 1'b0);
    check("rst_frameerr", rx_if.frameErr, 1'b0);
    check("rst_busy", rx_if.rxBusy, 1'b0);
    reset = 1'b1;
    idle(20);

    // Basic frame
    send_frame(8'hA5, 1'b1);
    idle(50);
    check("a5_count", nd_cnt, 1);
    check("a5_pulse_data", nd_data[0], 8'hA5);
    check("a5_rxdata", rx_if.RxData, 8'hA5);
    check("a5_no_ferr", fe_cnt, 0);
    check("a5_busy_low", rx_if.rxBusy, 1'b0);

    // False start: 81-clk low glitch
    rx_if.RxD = 1'b0;
    idle(40);
    check("glitch_busy", rx_if.rxBusy, 1'b1);
    idle(41);
    rx_if.RxD = 1'b1;
    idle(2 * BIT);
    check("glitch_no_nd", nd_cnt, 1);
    check("glitch_no_fe", fe_cnt, 0);
    check("glitch_idle", rx_if.rxBusy, 1'b0);
    check("glitch_rxdata", rx_if.RxData, 8'hA5);

    // Framing error then line break, then recovery
    send_frame(8'h3C, 1'b0);
    check("brk_busy", rx_if.rxBusy, 1'b1);
    check("ferr_count", fe_cnt, 1);
    check("ferr_rxdata", rx_if.RxData, 8'hA5);
    check("ferr_no_nd", nd_cnt, 1);
    rx_if.RxD = 1'b1;
    idle(BIT);
    check("brk_exit", rx_if.rxBusy, 1'b0);
    send_frame(8'h5A, 1'b1);
    idle(50);
    check("5a_count", nd_cnt, 2);
    check("5a_rxdata", rx_if.RxData, 8'h5A);
    check("5a_fe_same", fe_cnt, 1);

    // Back-to-back frames, no idle gap
    idle(BIT);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(50);
    check("b2b_count", nd_cnt, 4);
    check("b2b_first", nd_data[2], 8'h00);
    check("b2b_second", nd_data[3], 8'hFF);
    check("b2b_spacing", nd_time[3] - nd_time[2], FRAME_BITS * BIT);

    // Reset in the middle of DATA of 0x81
    idle(BIT);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    idle(BIT / 2);
    check("pre_rst_busy", rx_if.rxBusy, 1'b1);
    reset = 1'b0;
    idle(1);
    check("mid_rst_rxdata", rx_if.RxData, 8'h00);
    check("mid_rst_nd", rx_if.isNewData, 1'b0);
    check("mid_rst_fe", rx_if.frameErr, 1'b0);
    check("mid_rst_busy", rx_if.rxBusy, 1'b0);
    idle(4);
    rx_if.RxD = 1'b1;
    reset = 1'b1;
    idle(2 * BIT);
    check("post_rst_no_nd", nd_cnt, 4);
    check("post_rst_no_fe", fe_cnt, 1);
    send_frame(8'h7E, 1'b1);
    idle(50);
    check("7e_count", nd_cnt, 5);
    check("7e_rxdata", rx_if.RxData, 8'h7E);

`ifdef RX_PARITY_EN
    send_bad_par(8'h55);
    idle(50);
    check("par_bad_fe", fe_cnt, 2);
    check("par_bad_rxdata", rx_if.RxData, 8'h7E);
    check("par_bad_no_nd", nd_cnt, 5);
    send_frame(8'h55, 1'b1);
    idle(50);
    check("par_ok_count", nd_cnt, 6);
    check("par_ok_rxdata", rx_if.RxData, 8'h55);
`endif

    check("never_both", both_cnt, 0);
    check("nd_one_clk", nd_long, 0);
    check("fe_one_clk", fe_long, 0);
    check("busy_falls_with_nd", busy_at_nd, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
